ram_dp_sync_init: RTL and testbench
===================================

Name: ram_dp_sync_init

Overview:
Next-generation simple dual-port RAM: one write port and one read port on a single clock. Adds a registered read pipeline with a valid flag, per-lane write enables and a selectable read-during-write policy. A built-in init engine fills the whole array with a constant after reset or on request. It is the standard storage primitive for the RAM-to-RAM transfer datapath.

Parameters:
DEPTH, 16, number of words; any value >= 2, need not be a power of two
WIDTH, 8, word width in bits; must be a multiple of LANE_W
LANE_W, 8, bits per write-enable lane
LANES, WIDTH/LANE_W, number of write lanes (derived)
DEPTH_LOG, $clog2(DEPTH), address width (derived)
RD_LATENCY, 1, read latency in cycles; legal values 1 or 2
RDW_MODE, 0, same-address read/write collision policy: 0 = read-first (old data), 1 = write-first (new data)
INIT_VAL, 0, WIDTH-bit value written to every word by the init engine

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
init_req  input  1  single-cycle request to re-initialise the array; honoured only when init_busy=0
init_busy  output  1  high while the init engine owns the array
wr_en  input  1  write request
wr_be  input  LANES  per-lane write enable; lane i covers bits [i*LANE_W +: LANE_W]
addr_wr  input  DEPTH_LOG  write address
data_wr  input  WIDTH  write data
rd_en  input  1  read request
addr_rd  input  DEPTH_LOG  read address
data_rd  output  WIDTH  read data; valid only when rd_valid=1
rd_valid  output  1  one-cycle pulse marking data_rd valid

Behaviour:
- Reset (rst_n=0, asynchronous): FSM goes to INIT, init address counter = 0, init_busy=1, rd_valid=0, data_rd=0, read pipeline cleared. Array contents are not reset directly.
- FSM has two states: INIT and READY.
- INIT: each rising edge writes INIT_VAL to word[cnt] (all lanes), then cnt increments.
  - The edge that writes DEPTH-1 moves the FSM to READY.
  - init_busy falls after that edge, so it is high for exactly DEPTH cycles after reset release.
- INIT port handling: wr_en and rd_en are ignored and dropped, with no rd_valid generated. init_req is ignored.
- READY: init_req=1 moves to INIT with cnt=0; init_busy=1 from the next cycle. In that same request cycle, wr_en and rd_en are still serviced normally.
- Reads issued before entering INIT complete through the pipeline with their sampled data.
- Write (READY, wr_en=1): on the edge, lanes with wr_be[i]=1 are updated; other lanes keep their value. wr_be=0 is a no-op.
- Read (READY, rd_en=1): addr_rd is sampled on edge T.
  - data_rd and rd_valid=1 appear after edge T+RD_LATENCY-1, i.e. visible in cycle T+RD_LATENCY.
  - The pipeline is fully pipelined: one read per cycle, back-to-back reads give consecutive rd_valid pulses.
  - data_rd holds its last value when rd_valid=0.
- Collision (wr_en, rd_en, addr_wr==addr_rd in the same cycle):
  - RDW_MODE=0: the read returns the pre-write word.
  - RDW_MODE=1: the read returns the merged word, i.e. new lanes where wr_be=1 and old lanes elsewhere.
  - The write always commits.
- Out of range (address >= DEPTH, only possible for non-power-of-2 DEPTH): writes are dropped; reads return 0 with a normal rd_valid.
- Reset mid-INIT restarts the fill from address 0. Reset mid-read discards all in-flight reads.
- The second pipeline stage (RD_LATENCY=2) carries both data and valid; nothing is combinational from addr_rd to data_rd.

Test Plan:
- Reset release with DEPTH=16, INIT_VAL=8'hA5 -> init_busy high exactly 16 cycles; then reading addresses 0..15 returns 8'hA5 each, with rd_valid 1 cycle after rd_en.
- Write 8'h3C to addr 5, then rd_en at addr 5 next cycle -> data_rd=8'h3C with rd_valid one cycle later (RD_LATENCY=1). With RD_LATENCY=2 -> same data two cycles later.
- WIDTH=16, word at addr 2 = 16'h1234, write 16'hABCD with wr_be=2'b10 -> readback 16'hAB34.
- Collision at addr 7 (old 8'h11, write 8'h22): RDW_MODE=0 -> read 8'h11; RDW_MODE=1 -> read 8'h22. A subsequent read returns 8'h22 in both modes.
- init_req in READY with a read in flight -> the read completes with old data. rd_en and wr_en during the following 16 busy cycles produce no rd_valid and no writes; the array then reads INIT_VAL.
- DEPTH=12: write to addr 13 has no effect and a read at addr 13 returns 0 with rd_valid. Asserting rst_n=0 at init cycle 6 -> fill restarts and init_busy stays high 12 cycles after release.

Source files
------------

// File: rtl/ram_dp_sync_init_if.sv
// Bus bundle for ram_dp_sync_init: init control, write port and read port.
// The master drives requests and the slave (the RAM) returns status and read data.
interface ram_dp_sync_init_if #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 8,
  parameter int LANE_W = 8
);
  localparam int LANES     = WIDTH / LANE_W;
  localparam int DEPTH_LOG = $clog2(DEPTH);

  logic                 init_req;
  logic                 init_busy;
  logic                 wr_en;
  logic [LANES-1:0]     wr_be;
  logic [DEPTH_LOG-1:0] addr_wr;
  logic [WIDTH-1:0]     data_wr;
  logic                 rd_en;
  logic [DEPTH_LOG-1:0] addr_rd;
  logic [WIDTH-1:0]     data_rd;
  logic                 rd_valid;

  modport master (
    output init_req, wr_en, wr_be, addr_wr, data_wr, rd_en, addr_rd,
    input  init_busy, data_rd, rd_valid
  );

  modport slave (
    input  init_req, wr_en, wr_be, addr_wr, data_wr, rd_en, addr_rd,
    output init_busy, data_rd, rd_valid
  );
endinterface

// File: rtl/ram_dp_sync_init.sv
// Simple dual-port RAM with lane write enables, registered read pipeline,
// selectable read-during-write policy and a fill-with-constant init engine.
module ram_dp_sync_init #(
  parameter int               DEPTH      = 16,
  parameter int               WIDTH      = 8,
  parameter int               LANE_W     = 8,
  parameter int               LANES      = WIDTH / LANE_W,
  parameter int               DEPTH_LOG  = $clog2(DEPTH),
  parameter int               RD_LATENCY = 1,
  parameter int               RDW_MODE   = 0,
  parameter logic [WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  ram_dp_sync_init_if.slave  bus
);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  localparam logic [DEPTH_LOG:0]   DEPTH_EXT = (DEPTH_LOG + 1)'(DEPTH);
  localparam logic [DEPTH_LOG-1:0] LAST_ADDR = DEPTH_LOG'(DEPTH - 1);

  state_t               state_reg;
  logic [DEPTH_LOG-1:0] cnt_reg;
  logic                 init_busy_reg;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [WIDTH-1:0]     mem_rd_reg;

  logic                 ready;
  logic                 wr_oor;
  logic                 rd_oor;
  logic                 wr_fire;
  logic                 rd_fire;
  logic [DEPTH_LOG-1:0] rd_addr_safe;
  logic [DEPTH_LOG-1:0] mem_waddr;
  logic [WIDTH-1:0]     mem_wdata;
  logic [LANES-1:0]     mem_lane_we;

  logic                 valid1_reg;
  logic                 zero1_reg;
  logic [LANES-1:0]     coll_be_reg;
  logic [WIDTH-1:0]     wdata1_reg;
  logic [WIDTH-1:0]     data1;

  assign ready        = (state_reg == ST_READY);
  assign wr_oor       = {1'b0, bus.addr_wr} >= DEPTH_EXT;
  assign rd_oor       = {1'b0, bus.addr_rd} >= DEPTH_EXT;
  assign wr_fire      = ready && bus.wr_en && !wr_oor;
  assign rd_fire      = ready && bus.rd_en;
  assign rd_addr_safe = rd_oor ? '0 : bus.addr_rd;

  // The init engine owns the write port while filling; user writes take it otherwise.
  assign mem_waddr = ready ? bus.addr_wr : cnt_reg;
  assign mem_wdata = ready ? bus.data_wr : INIT_VAL;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_we
      assign mem_lane_we[gi] = ready ? (wr_fire && bus.wr_be[gi]) : 1'b1;
    end
  endgenerate

  // Storage and its read register carry no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (mem_lane_we[i]) begin
        mem[mem_waddr][i*LANE_W +: LANE_W] <= mem_wdata[i*LANE_W +: LANE_W];
      end
    end
    if (rd_fire) begin
      mem_rd_reg <= mem[rd_addr_safe];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_INIT;
      cnt_reg       <= '0;
      init_busy_reg <= 1'b1;
    end else begin
      case (state_reg)
        ST_INIT: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_ADDR) begin
            state_reg     <= ST_READY;
            init_busy_reg <= 1'b0;
            cnt_reg       <= '0;
          end
        end
        default: begin
          if (bus.init_req) begin
            state_reg     <= ST_INIT;
            init_busy_reg <= 1'b1;
            cnt_reg       <= '0;
          end
        end
      endcase
    end
  end

  // Side information captured with each read: out-of-range flag and colliding lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1_reg  <= 1'b0;
      zero1_reg   <= 1'b1;
      coll_be_reg <= '0;
      wdata1_reg  <= '0;
    end else begin
      valid1_reg <= rd_fire;
      if (rd_fire) begin
        zero1_reg   <= rd_oor;
        wdata1_reg  <= bus.data_wr;
        coll_be_reg <= (RDW_MODE == 1 && wr_fire && bus.addr_wr == bus.addr_rd)
                       ? bus.wr_be : '0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_merge
      assign data1[gi*LANE_W +: LANE_W] =
          zero1_reg       ? '0 :
          coll_be_reg[gi] ? wdata1_reg[gi*LANE_W +: LANE_W] :
                            mem_rd_reg[gi*LANE_W +: LANE_W];
    end
  endgenerate

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [WIDTH-1:0] data2_reg;
      logic             valid2_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data2_reg  <= '0;
          valid2_reg <= 1'b0;
        end else begin
          valid2_reg <= valid1_reg;
          if (valid1_reg) begin
            data2_reg <= data1;
          end
        end
      end

      assign bus.data_rd  = data2_reg;
      assign bus.rd_valid = valid2_reg;
    end else begin : g_lat1
      assign bus.data_rd  = data1;
      assign bus.rd_valid = valid1_reg;
    end
  endgenerate

  assign bus.init_busy = init_busy_reg;

endmodule

// File: tb/tb_ram_dp_sync_init.sv
// Directed bench: four RAM configurations share one stimulus bus and are
// checked against hand-computed values.
module tb_ram_dp_sync_init;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst_n_d;
  logic        init_req;
  logic        wr_en;
  logic        rd_en;
  logic [1:0]  wr_be;
  logic [3:0]  addr_wr;
  logic [3:0]  addr_rd;
  logic [15:0] data_wr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // a: latency 1 read-first, b: latency 2 write-first, c: two lanes, d: DEPTH 12
  ram_dp_sync_init_if #(.DEPTH(16), .WIDTH(8),  .LANE_W(8)) if_a ();
  ram_dp_sync_init_if #(.DEPTH(16), .WIDTH(8),  .LANE_W(8)) if_b ();
  ram_dp_sync_init_if #(.DEPTH(16), .WIDTH(16), .LANE_W(8)) if_c ();
  ram_dp_sync_init_if #(.DEPTH(12), .WIDTH(8),  .LANE_W(8)) if_d ();

  assign if_a.init_req = init_req;
  assign if_a.wr_en    = wr_en;
  assign if_a.wr_be    = wr_be[0:0];
  assign if_a.addr_wr  = addr_wr;
  assign if_a.data_wr  = data_wr[7:0];
  assign if_a.rd_en    = rd_en;
  assign if_a.addr_rd  = addr_rd;

  assign if_b.init_req = init_req;
  assign if_b.wr_en    = wr_en;
  assign if_b.wr_be    = wr_be[0:0];
  assign if_b.addr_wr  = addr_wr;
  assign if_b.data_wr  = data_wr[7:0];
  assign if_b.rd_en    = rd_en;
  assign if_b.addr_rd  = addr_rd;

  assign if_c.init_req = init_req;
  assign if_c.wr_en    = wr_en;
  assign if_c.wr_be    = wr_be;
  assign if_c.addr_wr  = addr_wr;
  assign if_c.data_wr  = data_wr;
  assign if_c.rd_en    = rd_en;
  assign if_c.addr_rd  = addr_rd;

  assign if_d.init_req = init_req;
  assign if_d.wr_en    = wr_en;
  assign if_d.wr_be    = wr_be[0:0];
  assign if_d.addr_wr  = addr_wr;
  assign if_d.data_wr  = data_wr[7:0];
  assign if_d.rd_en    = rd_en;
  assign if_d.addr_rd  = addr_rd;

  ram_dp_sync_init #(.DEPTH(16), .WIDTH(8), .LANE_W(8), .RD_LATENCY(1),
                     .RDW_MODE(0), .INIT_VAL(8'hA5))
    u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  ram_dp_sync_init #(.DEPTH(16), .WIDTH(8), .LANE_W(8), .RD_LATENCY(2),
                     .RDW_MODE(1), .INIT_VAL(8'hA5))
    u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  ram_dp_sync_init #(.DEPTH(16), .WIDTH(16), .LANE_W(8), .RD_LATENCY(1),
                     .RDW_MODE(0), .INIT_VAL(16'h5A5A))
    u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
  ram_dp_sync_init #(.DEPTH(12), .WIDTH(8), .LANE_W(8), .RD_LATENCY(1),
                     .RDW_MODE(0), .INIT_VAL(8'h77))
    u_d (.clk(clk), .rst_n(rst_n_d), .bus(if_d));

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end else begin
      $display("chk  %s got %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_a;
    int n_c;
    int n;
    int va;
    int vb;
    logic [7:0] bdata;
    logic [3:0] la [3];

    rst_n    = 1'b0;
    rst_n_d  = 1'b0;
    init_req = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    wr_be    = 2'b00;
    addr_wr  = '0;
    addr_rd  = '0;
    data_wr  = '0;

    // Reset state
    step();
    step();
    chk("rst_busy_a",  16'(if_a.init_busy), 16'h1);
    chk("rst_valid_a", 16'(if_a.rd_valid),  16'h0);
    chk("rst_data_a",  16'(if_a.data_rd),   16'h0);
    chk("rst_data_b",  16'(if_b.data_rd),   16'h0);
    chk("rst_busy_d",  16'(if_d.init_busy), 16'h1);

    // Busy window after reset release
    rst_n = 1'b1;
    n_a = 0;
    n_c = 0;
    for (int k = 0; k < 40; k++) begin
      n_a += int'(if_a.init_busy);
      n_c += int'(if_c.init_busy);
      step();
    end
    chk("busy_cycles_a", 16'(n_a), 16'd16);
    chk("busy_cycles_c", 16'(n_c), 16'd16);

    // Back-to-back reads of the freshly filled array
    rd_en   = 1'b1;
    addr_rd = 4'd0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("fill_valid_a", 16'(if_a.rd_valid), 16'h1);
      chk("fill_data_a",  16'(if_a.data_rd),  16'h00A5);
      chk("fill_data_c",  if_c.data_rd,       16'h5A5A);
      if (i > 0) begin
        chk("fill_valid_b", 16'(if_b.rd_valid), 16'h1);
        chk("fill_data_b",  16'(if_b.data_rd),  16'h00A5);
      end
      addr_rd = addr_rd + 4'd1;
    end
    rd_en = 1'b0;
    step();
    chk("fill_last_b", 16'(if_b.rd_valid), 16'h1);
    chk("idle_valid_a", 16'(if_a.rd_valid), 16'h0);
    chk("hold_data_a",  16'(if_a.data_rd),  16'h00A5);
    step();
    chk("idle_valid_b", 16'(if_b.rd_valid), 16'h0);

    // Write then read, latency 1 vs 2
    wr_en = 1'b1; addr_wr = 4'd5; data_wr = 16'h003C; wr_be = 2'b11;
    step();
    wr_en = 1'b0; rd_en = 1'b1; addr_rd = 4'd5;
    step();
    rd_en = 1'b0;
    chk("wr5_valid_a", 16'(if_a.rd_valid), 16'h1);
    chk("wr5_data_a",  16'(if_a.data_rd),  16'h003C);
    chk("wr5_data_c",  if_c.data_rd,       16'h003C);
    chk("wr5_early_b", 16'(if_b.rd_valid), 16'h0);
    step();
    chk("wr5_valid_b", 16'(if_b.rd_valid), 16'h1);
    chk("wr5_data_b",  16'(if_b.data_rd),  16'h003C);
    chk("wr5_pulse_a", 16'(if_a.rd_valid), 16'h0);

    // Lane enables: upper lane only
    wr_en = 1'b1; addr_wr = 4'd2; data_wr = 16'h1234; wr_be = 2'b11;
    step();
    data_wr = 16'hABCD; wr_be = 2'b10;
    step();
    wr_en = 1'b0; rd_en = 1'b1; addr_rd = 4'd2;
    step();
    rd_en = 1'b0;
    chk("lane_data_c",  if_c.data_rd,      16'hAB34);
    chk("be0_noop_a",   16'(if_a.data_rd), 16'h0034);

    // Same-address collision
    wr_en = 1'b1; addr_wr = 4'd7; data_wr = 16'h0011; wr_be = 2'b11;
    step();
    data_wr = 16'h0022; rd_en = 1'b1; addr_rd = 4'd7;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("coll_old_a", 16'(if_a.data_rd), 16'h0011);
    chk("coll_old_c", if_c.data_rd,      16'h0011);
    step();
    chk("coll_new_b", 16'(if_b.data_rd), 16'h0022);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("after_coll_a", 16'(if_a.data_rd), 16'h0022);
    step();
    chk("after_coll_b", 16'(if_b.data_rd), 16'h0022);

    // Re-init with a read in flight; traffic during busy is dropped
    rd_en = 1'b1; addr_rd = 4'd5; init_req = 1'b1;
    step();
    init_req = 1'b0;
    wr_en = 1'b1; addr_wr = 4'd3; data_wr = 16'h0099; wr_be = 2'b11;
    chk("inflight_valid_a", 16'(if_a.rd_valid),  16'h1);
    chk("inflight_data_a",  16'(if_a.data_rd),   16'h003C);
    chk("reinit_busy_a",    16'(if_a.init_busy), 16'h1);
    n = 0; va = 0; vb = 0; bdata = 8'h00;
    while (if_a.init_busy && n < 100) begin
      step();
      n++;
      va += int'(if_a.rd_valid);
      if (if_b.rd_valid) begin
        vb++;
        bdata = if_b.data_rd;
      end
    end
    rd_en = 1'b0; wr_en = 1'b0;
    chk("reinit_busy_cycles", 16'(n),     16'd16);
    chk("busy_valid_a",       16'(va),    16'd0);
    chk("busy_valid_b",       16'(vb),    16'd1);
    chk("inflight_data_b",    16'(bdata), 16'h003C);
    la[0] = 4'd3; la[1] = 4'd5; la[2] = 4'd7;
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1; addr_rd = la[i];
      step();
      rd_en = 1'b0;
      chk("reinit_valid_a", 16'(if_a.rd_valid), 16'h1);
      chk("reinit_data_a",  16'(if_a.data_rd),  16'h00A5);
      chk("reinit_data_c",  if_c.data_rd,       16'h5A5A);
    end

    // DEPTH 12: reset during fill, then out-of-range accesses
    rst_n_d = 1'b1;
    repeat (6) step();
    chk("d_midfill_busy", 16'(if_d.init_busy), 16'h1);
    rst_n_d = 1'b0;
    #1;
    chk("d_rst_busy",  16'(if_d.init_busy), 16'h1);
    chk("d_rst_valid", 16'(if_d.rd_valid),  16'h0);
    step();
    rst_n_d = 1'b1;
    n = 0;
    while (if_d.init_busy && n < 100) begin
      step();
      n++;
    end
    chk("d_busy_cycles", 16'(n), 16'd12);
    wr_en = 1'b1; addr_wr = 4'd13; data_wr = 16'h0055; wr_be = 2'b11;
    step();
    addr_wr = 4'd11; data_wr = 16'h0066;
    step();
    wr_en = 1'b0; rd_en = 1'b1; addr_rd = 4'd13;
    step();
    chk("d_oor_valid", 16'(if_d.rd_valid), 16'h1);
    chk("d_oor_data",  16'(if_d.data_rd),  16'h0000);
    addr_rd = 4'd11;
    step();
    chk("d_last_data", 16'(if_d.data_rd), 16'h0066);
    addr_rd = 4'd1;
    step();
    rd_en = 1'b0;
    chk("d_init_data", 16'(if_d.data_rd), 16'h0077);
    step();
    chk("d_idle_valid", 16'(if_d.rd_valid), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
